// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx
//   Serial output stage for the GPIO port. Each 32-bit word written through
//   wr_en is queued in a small circular FIFO and then sent on an 8N1 UART
//   line as four bytes, least-significant byte first. Consecutive words
//   and bytes are sent back to back, with no idle time between them.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 1)
//   FIFO_DEPTH    FIFO word entries (power of two, >= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   salida    GPIO word to transmit
//   wr_en     push salida into the FIFO this cycle
//   tx        UART serial line (registered, idle high)
//   busy      FIFO non-empty or serializer active
//   full      FIFO holds FIFO_DEPTH words (registered)
//   overflow  sticky flag: a write was dropped because the FIFO was full
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] salida,
  input  logic        wr_en,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Keep the baud counter at least one bit wide so CLKS_PER_BIT=1 still works.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             overflow_reg;

  // Serializer
  state_t           state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [1:0]       byte_idx_reg;
  logic [31:0]      shift_reg;
  logic             tx_reg;

  logic        baud_done;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] head_word;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_idx_inc;

  assign baud_done   = (baud_cnt_reg == BAUD_LAST);
  assign fifo_empty  = (count_reg == '0);
  assign head_word   = mem[rd_ptr_reg];
  assign cur_byte    = shift_reg[7:0];
  assign bit_idx_inc = bit_idx_reg + 3'd1;

  // full_reg always mirrors the pre-edge count, so a write to a full FIFO
  // is dropped even when the serializer pops in the same cycle.
  assign push = wr_en & ~full_reg;

  // The serializer pops either from IDLE or at the end of the last stop bit
  // of a word, which keeps consecutive words contiguous on the line.
  assign pop = ~fifo_empty &
               ((state_reg == IDLE) |
                ((state_reg == STOP) & baud_done & (byte_idx_reg == 2'd3)));

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset; a reset simply rewinds the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= salida;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg    <= count_next;
      full_reg     <= (count_next == DEPTH_C);
      overflow_reg <= overflow_reg | (wr_en & full_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
          if (pop) begin
            shift_reg    <= head_word;
            byte_idx_reg <= 2'd0;
            state_reg    <= START;
            tx_reg       <= 1'b0;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= 3'd0;
            state_reg    <= DATA;
            tx_reg       <= cur_byte[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_inc;
              tx_reg      <= cur_byte[bit_idx_inc];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (byte_idx_reg != 2'd3) begin
              // Next byte of the same word moves into the low byte.
              shift_reg    <= {8'd0, shift_reg[31:8]};
              byte_idx_reg <= byte_idx_reg + 2'd1;
              state_reg    <= START;
              tx_reg       <= 1'b0;
            end else if (pop) begin
              shift_reg    <= head_word;
              byte_idx_reg <= 2'd0;
              state_reg    <= START;
              tx_reg       <= 1'b0;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign busy     = ~fifo_empty | (state_reg != IDLE);
  assign full     = full_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_gpio_uart_tx.sv
module tb_gpio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] salida;
  logic        wr_en;
  logic        tx, busy, full, overflow;
  logic [31:0] salida1;
  logic        wr_en1;
  logic        tx1, busy1, full1, overflow1;

  always #5 clk = ~clk;

  gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .salida(salida), .wr_en(wr_en),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  gpio_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .salida(salida1), .wr_en(wr_en1),
    .tx(tx1), .busy(busy1), .full(full1), .overflow(overflow1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of accepted words and queue of line levels still
  // to appear on tx, one entry per clock cycle.
  logic [31:0] fq[$];
  bit          bq[$];
  bit          m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // k-th bit (0..39) of the 8N1 frame sequence for a word, LSB byte first.
  function automatic bit word_bit(input logic [31:0] w, input int k);
    int byte_n = k / 10;
    int pos    = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[byte_n * 8 + pos - 1];
  endfunction

  task automatic model_reset();
    fq.delete();
    bq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [31:0] d);
    bit full_pre;
    logic [31:0] word;
    full_pre = (fq.size() == DEPTH);
    if (bq.size() > 0) void'(bq.pop_front());
    if (bq.size() == 0 && fq.size() > 0) begin
      word = fq.pop_front();
      for (int k = 0; k < 40 * CPB; k++) bq.push_back(word_bit(word, k / CPB));
    end
    if (w) begin
      if (!full_pre) fq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  // Called at a falling edge: drives inputs, steps one rising edge, checks.
  task automatic cycle(input logic w, input logic [31:0] d);
    logic exp_tx;
    wr_en  = w;
    salida = d;
    @(posedge clk);
    model_edge(w, d);
    @(negedge clk);
    exp_tx = (bq.size() > 0) ? bq[0] : 1'b1;
    check_val("tx", tx, exp_tx);
    check_val("busy", busy, (fq.size() != 0 || bq.size() != 0));
    check_val("full", full, fq.size() == DEPTH);
    check_val("overflow", overflow, m_ovf);
  endtask

  initial begin
    int burst;
    logic w;

    rst = 1'b1; wr_en = 1'b0; salida = '0; wr_en1 = 1'b0; salida1 = '0;
    burst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_full", full, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_tx1", tx1, 1);
    rst = 1'b0;

    // Quiet line after reset
    repeat (1000) cycle(1'b0, '0);

    // Single word
    cycle(1'b1, 32'hA5C30F81);
    repeat (170) cycle(1'b0, '0);

    // Burst of six words into a four-deep FIFO
    for (int i = 1; i <= 6; i++) cycle(1'b1, 32'(i));
    repeat (820) cycle(1'b0, '0);

    // Back-to-back extremes
    cycle(1'b1, 32'h00000000);
    cycle(1'b1, 32'hFFFFFFFF);
    repeat (330) cycle(1'b0, '0);

    // Reset during DATA bit 3 of byte 2
    cycle(1'b1, $urandom);
    repeat (97) cycle(1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_tx", tx, 1);
    check_val("arst_busy", busy, 0);
    check_val("arst_full", full, 0);
    check_val("arst_ovf", overflow, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h12345678);
    repeat (170) cycle(1'b0, '0);

    // Randomized traffic with occasional bursts
    repeat (2500) begin
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(2, 7);
      if (burst > 0) begin
        w = 1'b1;
        burst--;
      end else begin
        w = ($urandom_range(0, 59) == 0);
      end
      cycle(w, $urandom);
    end
    repeat (900) cycle(1'b0, '0);

    // One cycle per bit instance
    salida1 = 32'h000000AA;
    wr_en1  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en1 = 1'b0;
    check_val("c1_tx_e0", tx1, 1);
    check_val("c1_busy_e0", busy1, 1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("c1_tx", tx1, word_bit(32'h000000AA, k));
    end
    @(posedge clk);
    @(negedge clk);
    check_val("c1_tx_end", tx1, 1);
    check_val("c1_busy_end", busy1, 0);
    check_val("c1_full", full1, 0);
    check_val("c1_ovf", overflow1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_uart_tx.md
# gpio_uart_tx

Serial output stage for the RISC-V core: captures each 32-bit word written to the GPIO output port and sends it off-chip over a UART line (8N1). It sits directly downstream of the GPIO block and consumes its `salida` word plus a one-cycle write strobe. A small FIFO absorbs bursts of GPIO writes while a baud-rate FSM serializes each word as four bytes, least-significant byte first.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 1.
- `FIFO_DEPTH`, 4, word entries in the input FIFO; power of two, ≥ 2.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `salida`  in  32  GPIO output word to transmit.
- `wr_en`  in  1  push `salida` into the FIFO this cycle.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- FIFO: circular buffer, read/write pointers plus count, all `$clog2(FIFO_DEPTH)`/`+1` bits wide; pointers wrap modulo FIFO_DEPTH.
- Push: `wr_en & !full` writes `salida` at the write pointer. `full` is evaluated on the pre-edge count; a push to a full FIFO is dropped even if a pop happens in the same cycle, and `overflow` is set (cleared only by `rst`).
- Simultaneous push and pop on a non-full FIFO: both take effect; count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop the head word into a 32-bit shift register, byte index=0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: `tx` = current byte bit [bit index], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At its end: if byte index<3, advance index (shift register right by 8) and go to START (no gap); else if FIFO non-empty, pop the next word and go to START (no gap); else IDLE.
- Byte order per word: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- Baud counter counts 0..CLKS_PER_BIT-1, resets on every state/bit change; CLKS_PER_BIT=1 gives one cycle per bit.
- `tx` is registered (no glitches).

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0, FSM=IDLE, FIFO empty, counters 0. Reset asserted mid-frame drives `tx` high immediately; the partial byte and all FIFO contents are discarded.
- Latency: `wr_en` sampled at edge E0 with FSM IDLE and FIFO empty → word stored at E0, popped at E1, `tx` low from E1.
- One word occupies exactly 40×CLKS_PER_BIT cycles of `tx`; back-to-back words are contiguous.
- `busy` rises at the edge that pushes into an empty FIFO while IDLE and falls at the edge ending the last STOP bit with the FIFO empty.
- `full` and `overflow` are registered; they update at the edge that causes the condition.

## Test plan
- CLKS_PER_BIT=4: single write of 0xA5C30F81 → `tx` carries frames 0x81, 0x0F, 0xC3, 0xA5 (start 0, LSB first, stop 1), 160 cycles total, then `busy`=0, `tx`=1.
- CLKS_PER_BIT=4, FIFO_DEPTH=4: six `wr_en` on consecutive cycles (words 1..6) while idle → words 1–5 accepted (word 1 popped at E1), `full`=1 after E4, word 6 dropped, `overflow`=1; 800 contiguous cycles of frames for words 1–5 in order.
- Write 0x00000000 and 0xFFFFFFFF back-to-back → no idle gap between the fourth stop bit of word 1 and the first start bit of word 2.
- Assert `rst` during DATA bit 3 of byte 2 → `tx`=1 asynchronously, all outputs at reset values; a subsequent write of 0x12345678 transmits cleanly from byte 0x78.
- CLKS_PER_BIT=1: write 0x000000AA → 40-cycle frame sequence, each bit exactly one cycle.
- No `wr_en` for 1000 cycles after reset → `tx` stays 1, `busy` stays 0.
